// File: rtl/decoder_3_to_8_pkg.sv
// Shared widths and the one-hot decode function for the 3-to-8 decoder.
// Any unknown select or enable bit falls through to the all-zero default.
package decoder_3_to_8_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    function automatic logic [OUT_W-1:0] dec_onehot(input logic [SEL_W-1:0] sel, input logic en);
        logic [OUT_W-1:0] y;
        y = '0;
        // Exact case matching keeps X/Z on any input from reaching the outputs.
        case ({en, sel})
            4'b1000: y = 8'b0000_0001;
            4'b1001: y = 8'b0000_0010;
            4'b1010: y = 8'b0000_0100;
            4'b1011: y = 8'b0000_1000;
            4'b1100: y = 8'b0001_0000;
            4'b1101: y = 8'b0010_0000;
            4'b1110: y = 8'b0100_0000;
            4'b1111: y = 8'b1000_0000;
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/decoder_3_to_8_core.sv
// Purely combinational one-hot decode; zero latency, no clock, no backpressure.
module decoder_3_to_8_core
    import decoder_3_to_8_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] y
);

    always_comb begin
        y = dec_onehot(sel, en);
    end

endmodule

// File: rtl/decoder_3_to_8.sv
// 3-to-8 decoder with combinational Y lines, a registered copy and a sticky activity flag.
// Optional saturating enable-cycle counter on act_cnt when DECODER_3_TO_8_ACTCNT_EN is defined.
module decoder_3_to_8
    import decoder_3_to_8_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             en,
    output logic             Y0,
    output logic             Y1,
    output logic             Y2,
    output logic             Y3,
    output logic             Y4,
    output logic             Y5,
    output logic             Y6,
    output logic             Y7,
    output logic [OUT_W-1:0] y_q,
    output logic             seen_q
`ifdef DECODER_3_TO_8_ACTCNT_EN
    ,
    output logic [CNT_W-1:0] act_cnt
`endif
);

    logic [OUT_W-1:0] y_dec;
    logic [OUT_W-1:0] y_d;
    logic             seen_d;

    decoder_3_to_8_core u_core (
        .sel (({A, B, C})),
        .en  (en),
        .y   (y_dec)
    );

    assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y_dec;

    always_comb begin
        y_d    = y_dec;
        seen_d = seen_q | (|y_dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= '0;
            seen_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            seen_q <= seen_d;
        end
    end

`ifdef DECODER_3_TO_8_ACTCNT_EN
    logic [CNT_W-1:0] act_cnt_d;
    logic [CNT_W-1:0] act_cnt_q;

    // Hold at all-ones instead of wrapping.
    always_comb begin
        act_cnt_d = act_cnt_q;
        if (en && (act_cnt_q != {CNT_W{1'b1}})) begin
            act_cnt_d = act_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cnt_q <= '0;
        end else begin
            act_cnt_q <= act_cnt_d;
        end
    end

    assign act_cnt = act_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Self-checking bench: directed cases from the decoder's behaviour, then random stimulus
// compared against an arithmetic reference model of Y, y_q, seen_q and act_cnt.
module tb_decoder_3_to_8;

    localparam int TB_CNT_W = 2;

    logic clk;
    logic rst_n;
    logic A, B, C, en;
    logic Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
    logic [7:0] y_q;
    logic seen_q;
`ifdef DECODER_3_TO_8_ACTCNT_EN
    logic [TB_CNT_W-1:0] act_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_yq;
    logic       exp_seen;
    int         exp_cnt;
    int         cnt_max;

    decoder_3_to_8 #(.CNT_W(TB_CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .C      (C),
        .en     (en),
        .Y0     (Y0),
        .Y1     (Y1),
        .Y2     (Y2),
        .Y3     (Y3),
        .Y4     (Y4),
        .Y5     (Y5),
        .Y6     (Y6),
        .Y7     (Y7),
        .y_q    (y_q),
        .seen_q (seen_q)
`ifdef DECODER_3_TO_8_ACTCNT_EN
        ,
        .act_cnt(act_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_y(input logic e, input int k);
        int v;
        v = e ? (1 << k) : 0;
        return v[7:0];
    endfunction

    function automatic logic [7:0] y_bus();
        return {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_y_q"}, 32'(y_q), 32'(exp_yq));
        check({tag, "_seen_q"}, 32'(seen_q), 32'(exp_seen));
        check({tag, "_onehot"}, 32'($countones(y_q) <= 1), 32'd1);
`ifdef DECODER_3_TO_8_ACTCNT_EN
        check({tag, "_act_cnt"}, 32'(act_cnt), exp_cnt);
`endif
    endtask

    // Apply inputs mid-cycle, check the combinational lines, then the registers after the edge.
    task automatic step(input logic e, input int k, input string tag);
        @(negedge clk);
        en = e;
        {A, B, C} = 3'(k);
        #1;
        check({tag, "_Y"}, 32'(y_bus()), 32'(ref_y(e, k)));
        @(posedge clk);
        exp_yq   = ref_y(e, k);
        exp_seen = exp_seen | (exp_yq != 8'h00);
        if (e && exp_cnt < cnt_max) exp_cnt++;
        #1;
        check_regs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cnt_max  = (1 << TB_CNT_W) - 1;
        exp_yq   = 8'h00;
        exp_seen = 1'b0;
        exp_cnt  = 0;
        rst_n = 1'b0;
        en = 1'b0;
        {A, B, C} = 3'b000;
        #12;
        check("reset_Y", 32'(y_bus()), 32'h00);
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b0, 0, "en0_000");
        step(1'b1, 0, "en1_000");
        step(1'b1, 2, "en1_010");
        step(1'b1, 4, "en1_100");
        step(1'b1, 6, "en1_110");
        for (int k = 0; k < 8; k++) step(1'b1, k, "sweep");
        step(1'b1, 6, "pre_drop");
        step(1'b0, 6, "en_drop");

        // Asynchronous reset asserted between edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_yq = 8'h00; exp_seen = 1'b0; exp_cnt = 0;
        check_regs("async_rst");
        en = 1'b1;
        {A, B, C} = 3'b011;
        #1;
        check("rst_Y_follow", 32'(y_bus()), 32'h08);
        @(posedge clk);
        #1;
        check_regs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5, "post_rst");

        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
